// File: rtl/tdc_selftest_pkg.sv
// Shared encodings for the TDC thermometer self-test pattern source.
package tdc_selftest_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_SWEEP = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] WMAX = 2'd3;

endpackage

// File: rtl/therm_window_gen.sv
// Combinational thermometer window builder plus the encoder result it should produce.
module therm_window_gen
  import tdc_selftest_pkg::*;
(
  input  logic [2:0] pos,
  input  logic [1:0] w,
  input  logic       bubble_en,
  input  logic [1:0] level,
  output logic [7:0] therm,
  output logic [2:0] exp_bin,
  output logic       exp_error,
  output logic       exp_bubble
);

  logic [3:0] sum;
  logic [2:0] top;
  logic [2:0] span;

  // Window edges saturate at bit 7; bubble knocks out the bit just above pos.
  always_comb begin
    sum  = {1'b0, pos} + {2'b00, w} - 4'd1;
    top  = (sum > 4'd7) ? 3'd7 : sum[2:0];
    span = top - pos;
    for (int i = 0; i < 8; i++) begin
      therm[i] = (3'(i) >= pos) && (3'(i) <= top);
    end
    if (bubble_en && (span >= 3'd2)) begin
      therm[pos + 3'd1] = 1'b0;
    end
    exp_bubble = (span != 3'd0);
    exp_error  = (span >= {1'b0, level});
    if (exp_error) begin
      exp_bin = 3'd0;
    end else if (span <= 3'd1) begin
      exp_bin = pos;
    end else begin
      exp_bin = pos + 3'd1;
    end
  end

endmodule

// File: rtl/tdc_therm_pattern_gen.sv
// Self-test stimulus source: walks thermometer windows and emits expected encoder results.
module tdc_therm_pattern_gen
  import tdc_selftest_pkg::*;
#(
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [2:0]       fix_pos,
  input  logic [1:0]       width,
  input  logic             bubble_en,
  input  logic [1:0]       level,
  input  logic [NUM_W-1:0] num_patterns,
  output logic [7:0]       therm_out,
  output logic [2:0]       exp_bin,
  output logic             exp_error,
  output logic             exp_bubble,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = NUM_W + 1;

  state_e           state_q;
  mode_e            mode_q;
  logic [2:0]       pos_q, pos_d;
  logic [1:0]       w_q, w_d;
  logic             bub_q;
  logic [1:0]       level_q;
  logic [CNT_W-1:0] count_q;

  logic [7:0] therm_q;
  logic [2:0] bin_q;
  logic       err_q, bubble_q, valid_q, busy_q, done_q;

  logic [7:0] win_therm;
  logic [2:0] win_bin;
  logic       win_err, win_bubble;

  therm_window_gen u_win (
    .pos       (pos_q),
    .w         (w_q),
    .bubble_en (bub_q),
    .level     (level_q),
    .therm     (win_therm),
    .exp_bin   (win_bin),
    .exp_error (win_err),
    .exp_bubble(win_bubble)
  );

  // Next window position/width: ramp modes step pos, sweep also rotates width on each wrap.
  always_comb begin
    pos_d = pos_q;
    w_d   = w_q;
    if (mode_q != MODE_FIXED) begin
      pos_d = pos_q + 3'd1;
      if ((mode_q == MODE_SWEEP) && (pos_q == 3'd7)) begin
        w_d = (w_q == WMAX) ? 2'd1 : w_q + 2'd1;
      end
    end
  end

  // Run-control FSM with registered outputs; outputs are zero whenever no pattern is valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_FIXED;
      pos_q    <= '0;
      w_q      <= '0;
      bub_q    <= 1'b0;
      level_q  <= '0;
      count_q  <= '0;
      therm_q  <= '0;
      bin_q    <= '0;
      err_q    <= 1'b0;
      bubble_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      therm_q  <= '0;
      bin_q    <= '0;
      err_q    <= 1'b0;
      bubble_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= (mode == 2'd3) ? MODE_FIXED : mode_e'(mode);
            pos_q   <= fix_pos;
            w_q     <= (width == 2'd0) ? 2'd1 : width;
            bub_q   <= bubble_en;
            level_q <= level;
            count_q <= (num_patterns == '0) ? {1'b1, {NUM_W{1'b0}}}
                                            : {1'b0, num_patterns};
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          therm_q  <= win_therm;
          bin_q    <= win_bin;
          err_q    <= win_err;
          bubble_q <= win_bubble;
          valid_q  <= 1'b1;
          pos_q    <= pos_d;
          w_q      <= w_d;
          count_q  <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign therm_out  = therm_q;
  assign exp_bin    = bin_q;
  assign exp_error  = err_q;
  assign exp_bubble = bubble_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tdc_therm_pattern_gen.sv
// Self-checking bench for tdc_therm_pattern_gen against an arithmetic window model.
module tb_tdc_therm_pattern_gen;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [1:0] mode;
  logic [2:0] fix_pos;
  logic [1:0] width;
  logic       bubble_en;
  logic [1:0] level;
  logic [7:0] num_patterns;
  logic [7:0] therm_out;
  logic [2:0] exp_bin;
  logic       exp_error;
  logic       exp_bubble;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int obs_therm[$];
  int obs_bin[$];

  tdc_therm_pattern_gen #(.NUM_W(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .mode        (mode),
    .fix_pos     (fix_pos),
    .width       (width),
    .bubble_en   (bubble_en),
    .level       (level),
    .num_patterns(num_patterns),
    .therm_out   (therm_out),
    .exp_bin     (exp_bin),
    .exp_error   (exp_error),
    .exp_bubble  (exp_bubble),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected {therm[7:0], bin[2:0], error, bubble} for one window, from plain arithmetic.
  function automatic logic [12:0] model(input int p, input int w, input int bub, input int lvl);
    int top, span, th, bn, er;
    top  = p + w - 1;
    if (top > 7) top = 7;
    span = top - p;
    th   = ((1 << (top + 1)) - (1 << p)) & 8'hFF;
    if (bub != 0 && span >= 2) th = th & ~(1 << (p + 1));
    er   = (span >= lvl) ? 1 : 0;
    if (er != 0)        bn = 0;
    else if (span <= 1) bn = p;
    else                bn = p + 1;
    return {th[7:0], bn[2:0], er[0], (span != 0)};
  endfunction

  // Launch one run and check every pattern, the valid count, latency and the done pulse.
  // poke_at >= 0 pulses a conflicting start after that many valid patterns.
  task automatic run(input int md_in, input int fp, input int w_in, input int bub,
                     input int lvl, input int n_in, input int poke_at);
    int md, w0, n, vcnt, first_idx, done_idx, p, w, budget, leak, busy_bad;
    logic [12:0] expv;
    logic poked;
    md = (md_in == 3) ? 0 : md_in;
    w0 = (w_in == 0) ? 1 : w_in;
    n  = (n_in == 0) ? 256 : n_in;
    obs_therm.delete();
    obs_bin.delete();
    @(negedge clk);
    mode = 2'(md_in); fix_pos = 3'(fp); width = 2'(w_in); bubble_en = bub[0];
    level = 2'(lvl); num_patterns = 8'(n_in); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vcnt = 0; first_idx = -1; done_idx = -1; leak = 0; busy_bad = 0; poked = 1'b0;
    budget = n + 10;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      if (poked) begin
        start = 1'b0;
        poked = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (first_idx < 0) first_idx = cyc;
        p = (md == 0) ? fp : (fp + vcnt) % 8;
        w = (md == 2) ? ((w0 - 1 + (fp + vcnt) / 8) % 3) + 1 : w0;
        expv = model(p, w, bub, lvl);
        obs_therm.push_back(int'(therm_out));
        obs_bin.push_back(int'(exp_bin));
        chk($sformatf("pattern%0d", vcnt), {19'd0, therm_out, exp_bin, exp_error, exp_bubble},
            {19'd0, expv});
        if (busy !== 1'b1) busy_bad++;
        vcnt++;
        if (vcnt == poke_at + 1 && poke_at >= 0) begin
          start = 1'b1; mode = 2'd1; fix_pos = 3'(fp + 3); width = 2'd3;
          bubble_en = ~bubble_en; level = 2'd0; num_patterns = 8'd5;
          poked = 1'b1;
        end
      end else begin
        if ({therm_out, exp_bin, exp_error, exp_bubble} !== 13'd0) leak++;
      end
      if (done === 1'b1) begin
        done_idx = cyc;
        chk("done_busy_low", {31'd0, busy}, 32'd0);
        chk("done_valid_low", {31'd0, out_valid}, 32'd0);
        break;
      end
    end
    chk("valid_count", vcnt, n);
    chk("first_valid_latency", first_idx, 0);
    chk("done_cycle", done_idx, n);
    chk("zero_when_invalid", leak, 0);
    chk("busy_during_run", busy_bad, 0);
    @(posedge clk); #1;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; mode = '0; fix_pos = '0; width = '0;
    bubble_en = 1'b0; level = '0; num_patterns = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {13'd0, therm_out, exp_bin, exp_error, exp_bubble, out_valid, busy, done},
        32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Fixed window
    run(0, 3, 1, 0, 1, 2, -1);
    chk("fixed_therm0", obs_therm[0], 32'h08);
    chk("fixed_bin0", obs_bin[0], 3);

    // Ramp across the top edge
    run(1, 6, 2, 0, 3, 3, -1);
    chk("ramp_therm1", obs_therm[1], 32'h80);
    chk("ramp_therm2", obs_therm[2], 32'h03);

    // Bubble, then the same window with a lower error threshold
    run(0, 2, 3, 1, 3, 1, -1);
    chk("bubble_therm", obs_therm[0], 32'h14);
    chk("bubble_bin", obs_bin[0], 3);
    run(0, 2, 3, 1, 2, 1, -1);
    chk("level2_bin", obs_bin[0], 0);

    // Width sweep over three wraps
    run(2, 0, 1, 0, 3, 24, -1);
    chk("sweep_therm16", obs_therm[16], 32'h07);
    chk("sweep_bin16", obs_bin[16], 1);

    // Full-length run with a mid-run start that must be ignored
    run(1, 5, 2, 1, 2, 0, 100);

    // Mode 3 and width 0 aliases
    run(3, 4, 0, 0, 1, 4, -1);

    // Reset in the middle of a run
    @(negedge clk);
    mode = 2'd1; fix_pos = 3'd1; width = 2'd2; bubble_en = 1'b0; level = 2'd3;
    num_patterns = 8'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrun_reset_outputs",
        {13'd0, therm_out, exp_bin, exp_error, exp_bubble, out_valid, busy, done}, 32'd0);
    begin
      int dseen;
      dseen = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done !== 1'b0 || out_valid !== 1'b0) dseen++;
      end
      chk("no_done_in_reset", dseen, 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    run(1, 7, 3, 1, 3, 9, -1);

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(1, 40)),
          -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
